cpu_mem_arbiter: RTL and testbench
==================================

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 64, bus cycles without wb_ack_i before abort (used only with CPU_MEM_ARBITER_TIMEOUT_EN).
REQ-002 SHALL have port: clk_i  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: if_req_i in 1, if_adr_i in 32: instruction-fetch request and word address.
REQ-005 SHALL have ports: if_ack_o out 1, if_dat_o out 32, if_err_o out 1: fetch completion pulse, read data, error pulse.
REQ-006 SHALL have port: flush_i  in  1  discard any in-flight fetch result.
REQ-007 SHALL have ports: dt_req_i in 1, dt_we_i in 1, dt_adr_i in 32, dt_dat_i in 32, dt_sel_i in 4: load/store request.
REQ-008 SHALL have ports: dt_ack_o out 1, dt_dat_o out 32, dt_err_o out 1: data completion pulse, read data, error pulse.
REQ-009 SHALL have ports: wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_adr_o, wb_dat_o out 32; wb_sel_o out 4: shared memory bus master.
REQ-010 SHALL have ports: wb_dat_i in 32, wb_ack_i in 1: bus read data and acknowledge.

Function
REQ-011 SHALL implement FSM states IDLE, IF_BUS, DT_BUS; all outputs registered.
REQ-012 In IDLE, eligible request sampled at edge k SHALL move FSM to owner's state and drive wb_cyc_o=wb_stb_o=1 plus latched address/data/sel/we from edge k.
REQ-013 Requester SHALL be ineligible in IDLE while its own ack_o or err_o is high (prevents re-grant of completed request).
REQ-014 Both eligible in IDLE: data SHALL win unless last grant was data, then fetch wins (alternation under continuous contention).
REQ-015 Fetch grant SHALL drive wb_we_o=0, wb_sel_o=4'hF, wb_dat_o=0.
REQ-016 wb_ack_i high at edge m in IF_BUS/DT_BUS SHALL: clear wb_cyc_o/wb_stb_o, pulse owner's ack_o for exactly one cycle, capture wb_dat_i into owner's dat_o, return to IDLE -- all from edge m.
REQ-017 dat_o SHALL hold last captured value until next completion for that requester.
REQ-018 wb_ack_i outside a bus cycle SHALL be ignored.
REQ-019 flush_i high at any edge while in IF_BUS (including edge of wb_ack_i) SHALL suppress the pending if_ack_o and if_dat_o update; bus cycle still completes normally.
REQ-020 flush_i high in IDLE SHALL block fetch grant at that edge; no other effect.
REQ-021 Back-to-back transactions SHALL be separated by at least one IDLE cycle (wb_cyc_o low).
REQ-022 Without the timeout feature, if_err_o and dt_err_o SHALL be constant 0.

Reset
REQ-023 rst_i low SHALL immediately force IDLE, last-grant flag = fetch, all outputs 0, timeout counter 0.
REQ-024 Reset mid-transaction SHALL drop wb_cyc_o/wb_stb_o without any ack_o/err_o pulse.
REQ-025 First edge after rst_i deasserts SHALL evaluate requests normally.

Configuration
REQ-026 Macro CPU_MEM_ARBITER_TIMEOUT_EN defined: counter cleared at grant, incremented each bus-cycle edge; reaching TIMEOUT_CYCLES without wb_ack_i SHALL drop wb_cyc_o/wb_stb_o, pulse owner's err_o one cycle (no ack_o, dat_o unchanged), return to IDLE.
REQ-027 wb_ack_i on the same edge as timeout SHALL win (normal completion, no err_o); flushed fetch timeout SHALL suppress if_err_o.
REQ-028 Macro undefined: no counter logic; bus cycle waits indefinitely for wb_ack_i.

Verification
REQ-029 Fetch only, if_adr_i=32'h1000, wb_ack_i after 2 cycles with wb_dat_i=32'h0123ABCD -> wb_adr_o=32'h1000, wb_we_o=0, one-cycle if_ack_o, if_dat_o=32'h0123ABCD.
REQ-030 Both requesting continuously, zero-wait memory -> grants D,F,D,F; wb_adr_o alternates dt/if address; idle cycle between each.
REQ-031 Store dt_adr_i=32'h2000, dt_dat_i=32'hDEADBEEF, dt_sel_i=4'b0011 -> wb_we_o=1, wb_sel_o=4'b0011, wb_dat_o=32'hDEADBEEF, dt_ack_o one pulse.
REQ-032 flush_i pulsed during IF_BUS -> bus cycle completes, no if_ack_o, if_dat_o unchanged; next fetch acknowledged normally.
REQ-033 With CPU_MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=64, wb_ack_i never asserted -> dt_err_o pulse after 64 bus cycles, wb_cyc_o low; ack on edge 64 -> dt_ack_o, no dt_err_o.
REQ-034 rst_i low during DT_BUS -> outputs 0 immediately, no dt_ack_o; after release, pending fetch granted first.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one Wishbone-style bus master.
// Optional bus-cycle timeout abort: define CPU_MEM_ARBITER_TIMEOUT_EN.
module cpu_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_adr_i,
  output logic        if_ack_o,
  output logic [31:0] if_dat_o,
  output logic        if_err_o,
  input  logic        flush_i,
  input  logic        dt_req_i,
  input  logic        dt_we_i,
  input  logic [31:0] dt_adr_i,
  input  logic [31:0] dt_dat_i,
  input  logic [3:0]  dt_sel_i,
  output logic        dt_ack_o,
  output logic [31:0] dt_dat_o,
  output logic        dt_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IF_BUS = 2'd1,
    S_DT_BUS = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      r_state;
  logic        r_last_dt;
  logic        r_if_flushed;
  logic        r_wb_cyc;
  logic        r_wb_we;
  logic [31:0] r_wb_adr;
  logic [31:0] r_wb_dat;
  logic [3:0]  r_wb_sel;
  logic        r_if_ack;
  logic [31:0] r_if_dat;
  logic        r_dt_ack;
  logic [31:0] r_dt_dat;

  logic        w_if_err;
  logic        w_dt_err;
  logic        w_if_elig;
  logic        w_dt_elig;
  logic        w_grant_dt;
  logic        w_grant_if;
  logic        w_if_drop;

`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             r_if_err;
  logic             r_dt_err;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_tmo_hit;

  assign w_if_err  = r_if_err;
  assign w_dt_err  = r_dt_err;
  // Counter holds the number of bus edges already seen; this edge is number TIMEOUT_CYCLES
  assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_if_err  = 1'b0;
  assign w_dt_err  = 1'b0;
`endif

  // A requester whose completion pulse is still visible must not be granted again
  assign w_if_elig  = if_req_i & ~r_if_ack & ~w_if_err & ~flush_i;
  assign w_dt_elig  = dt_req_i & ~r_dt_ack & ~w_dt_err;
  assign w_grant_dt = w_dt_elig & (~w_if_elig | ~r_last_dt);
  assign w_grant_if = w_if_elig & ~w_grant_dt;
  assign w_if_drop  = r_if_flushed | flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_last_dt    <= 1'b0;
      r_if_flushed <= 1'b0;
      r_wb_cyc     <= 1'b0;
      r_wb_we      <= 1'b0;
      r_wb_adr     <= 32'h0;
      r_wb_dat     <= 32'h0;
      r_wb_sel     <= 4'h0;
      r_if_ack     <= 1'b0;
      r_if_dat     <= 32'h0;
      r_dt_ack     <= 1'b0;
      r_dt_dat     <= 32'h0;
`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
      r_if_err     <= 1'b0;
      r_dt_err     <= 1'b0;
      r_tmo_cnt    <= '0;
`endif
    end else begin
      r_if_ack <= 1'b0;
      r_dt_ack <= 1'b0;
`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
      r_if_err <= 1'b0;
      r_dt_err <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_dt) begin
            r_state      <= S_DT_BUS;
            r_last_dt    <= 1'b1;
            r_wb_cyc     <= 1'b1;
            r_wb_we      <= dt_we_i;
            r_wb_adr     <= dt_adr_i;
            r_wb_dat     <= dt_dat_i;
            r_wb_sel     <= dt_sel_i;
            r_if_flushed <= 1'b0;
`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
          end else if (w_grant_if) begin
            r_state      <= S_IF_BUS;
            r_last_dt    <= 1'b0;
            r_wb_cyc     <= 1'b1;
            r_wb_we      <= 1'b0;
            r_wb_adr     <= if_adr_i;
            r_wb_dat     <= 32'h0;
            r_wb_sel     <= 4'hF;
            r_if_flushed <= 1'b0;
`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
          end
        end

        S_IF_BUS: begin
          if (flush_i) begin
            r_if_flushed <= 1'b1;
          end
          // A flush anywhere in the cycle, including the ack edge, hides the result
          if (wb_ack_i) begin
            r_state  <= S_IDLE;
            r_wb_cyc <= 1'b0;
            if (!w_if_drop) begin
              r_if_ack <= 1'b1;
              r_if_dat <= wb_dat_i;
            end
          end
`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_state  <= S_IDLE;
            r_wb_cyc <= 1'b0;
            if (!w_if_drop) begin
              r_if_err <= 1'b1;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          end
`endif
        end

        S_DT_BUS: begin
          if (wb_ack_i) begin
            r_state  <= S_IDLE;
            r_wb_cyc <= 1'b0;
            r_dt_ack <= 1'b1;
            r_dt_dat <= wb_dat_i;
          end
`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_state  <= S_IDLE;
            r_wb_cyc <= 1'b0;
            r_dt_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          end
`endif
        end

        default: begin
          r_state  <= S_IDLE;
          r_wb_cyc <= 1'b0;
        end
      endcase
    end
  end

  assign wb_cyc_o = r_wb_cyc;
  assign wb_stb_o = r_wb_cyc;
  assign wb_we_o  = r_wb_we;
  assign wb_adr_o = r_wb_adr;
  assign wb_dat_o = r_wb_dat;
  assign wb_sel_o = r_wb_sel;
  assign if_ack_o = r_if_ack;
  assign if_dat_o = r_if_dat;
  assign if_err_o = w_if_err;
  assign dt_ack_o = r_dt_ack;
  assign dt_dat_o = r_dt_dat;
  assign dt_err_o = w_dt_err;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_cpu_mem_arbiter;

  localparam int unsigned TMO = 64;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, flush_i, dt_req_i, dt_we_i, wb_ack_i;
  logic [31:0] if_adr_i, dt_adr_i, dt_dat_i, wb_dat_i;
  logic [3:0]  dt_sel_i;
  logic        if_ack_o, if_err_o, dt_ack_o, dt_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] if_dat_o, dt_dat_o, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_adr_i(if_adr_i),
    .if_ack_o(if_ack_o), .if_dat_o(if_dat_o), .if_err_o(if_err_o),
    .flush_i(flush_i),
    .dt_req_i(dt_req_i), .dt_we_i(dt_we_i), .dt_adr_i(dt_adr_i),
    .dt_dat_i(dt_dat_i), .dt_sel_i(dt_sel_i),
    .dt_ack_o(dt_ack_o), .dt_dat_o(dt_dat_o), .dt_err_o(dt_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: owner 0 = none, 1 = fetch, 2 = data
  int          own;
  int          cnt;
  bit          last_data, flushed;
  logic        e_cyc, e_we, e_if_ack, e_if_err, e_dt_ack, e_dt_err;
  logic [31:0] e_adr, e_wdat, e_if_dat, e_dt_dat;
  logic [3:0]  e_sel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    own = 0; cnt = 0; last_data = 0; flushed = 0;
    e_cyc = 0; e_we = 0; e_adr = 0; e_wdat = 0; e_sel = 0;
    e_if_ack = 0; e_if_dat = 0; e_if_err = 0;
    e_dt_ack = 0; e_dt_dat = 0; e_dt_err = 0;
  endfunction

  function automatic void model_step();
    bit if_busy, dt_busy, want_if, want_dt;
    if_busy = e_if_ack || e_if_err;
    dt_busy = e_dt_ack || e_dt_err;
    e_if_ack = 0; e_if_err = 0; e_dt_ack = 0; e_dt_err = 0;
    if (own == 0) begin
      want_if = if_req_i && !if_busy && !flush_i;
      want_dt = dt_req_i && !dt_busy;
      if (want_dt && !(want_if && last_data)) begin
        own = 2; last_data = 1; cnt = 0; flushed = 0;
        e_cyc = 1; e_we = dt_we_i; e_adr = dt_adr_i; e_wdat = dt_dat_i; e_sel = dt_sel_i;
      end else if (want_if) begin
        own = 1; last_data = 0; cnt = 0; flushed = 0;
        e_cyc = 1; e_we = 0; e_adr = if_adr_i; e_wdat = 0; e_sel = 4'hF;
      end
    end else begin
      if (own == 1 && flush_i) flushed = 1;
      if (wb_ack_i) begin
        e_cyc = 0;
        if (own == 2) begin
          e_dt_ack = 1; e_dt_dat = wb_dat_i;
        end else if (!flushed) begin
          e_if_ack = 1; e_if_dat = wb_dat_i;
        end
        own = 0;
      end else begin
        cnt++;
`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
        if (cnt == TMO) begin
          e_cyc = 0;
          if (own == 2) e_dt_err = 1;
          else if (!flushed) e_if_err = 1;
          own = 0;
        end
`endif
      end
    end
  endfunction

  task automatic compare_all();
    check_eq("wb_cyc", 32'(wb_cyc_o), 32'(e_cyc));
    check_eq("wb_stb", 32'(wb_stb_o), 32'(e_cyc));
    check_eq("wb_we", 32'(wb_we_o), 32'(e_we));
    check_eq("wb_adr", wb_adr_o, e_adr);
    check_eq("wb_dat", wb_dat_o, e_wdat);
    check_eq("wb_sel", 32'(wb_sel_o), 32'(e_sel));
    check_eq("if_ack", 32'(if_ack_o), 32'(e_if_ack));
    check_eq("if_dat", if_dat_o, e_if_dat);
    check_eq("if_err", 32'(if_err_o), 32'(e_if_err));
    check_eq("dt_ack", 32'(dt_ack_o), 32'(e_dt_ack));
    check_eq("dt_dat", dt_dat_o, e_dt_dat);
    check_eq("dt_err", 32'(dt_err_o), 32'(e_dt_err));
  endtask

  // One clock: DUT and model both see the inputs set at the previous falling edge
  task automatic cycle();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic drain();
    if_req_i = 0; dt_req_i = 0; flush_i = 0;
    for (int i = 0; i < 4; i++) begin
      wb_ack_i = e_cyc;
      cycle();
    end
    wb_ack_i = 0;
    cycle();
  endtask

  logic [31:0] grant_adr[$];
  logic [31:0] exp_grant[4];
  logic        prev_cyc;

  initial begin
    rst_i = 0; if_req_i = 0; if_adr_i = 0; flush_i = 0;
    dt_req_i = 0; dt_we_i = 0; dt_adr_i = 0; dt_dat_i = 0; dt_sel_i = 0;
    wb_dat_i = 0; wb_ack_i = 0;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(negedge clk_i);
    rst_i = 1;

    // Continuous contention with zero-wait memory: grants alternate D,F,D,F
    exp_grant = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
    if_req_i = 1; if_adr_i = 32'h1000;
    dt_req_i = 1; dt_we_i = 0; dt_adr_i = 32'h2000; dt_sel_i = 4'hF;
    prev_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      wb_ack_i = e_cyc;
      cycle();
      if (wb_cyc_o && !prev_cyc) grant_adr.push_back(wb_adr_o);
      prev_cyc = wb_cyc_o;
    end
    check_eq("grant_count", 32'(grant_adr.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < grant_adr.size(); i++)
      check_eq($sformatf("grant_order%0d", i), grant_adr[i], exp_grant[i]);
    drain();

    // Fetch with two-cycle memory latency
    if_req_i = 1; if_adr_i = 32'h1000;
    cycle();
    check_eq("fetch_adr", wb_adr_o, 32'h1000);
    check_eq("fetch_we", 32'(wb_we_o), 32'd0);
    if_req_i = 0;
    cycle();
    wb_ack_i = 1; wb_dat_i = 32'h0123ABCD;
    cycle();
    check_eq("fetch_ack", 32'(if_ack_o), 32'd1);
    check_eq("fetch_dat", if_dat_o, 32'h0123ABCD);
    wb_ack_i = 0;
    cycle();
    check_eq("fetch_ack_pulse", 32'(if_ack_o), 32'd0);

    // Store with partial byte select
    dt_req_i = 1; dt_we_i = 1; dt_adr_i = 32'h2000; dt_dat_i = 32'hDEADBEEF; dt_sel_i = 4'b0011;
    cycle();
    check_eq("store_we", 32'(wb_we_o), 32'd1);
    check_eq("store_sel", 32'(wb_sel_o), 32'h3);
    check_eq("store_dat", wb_dat_o, 32'hDEADBEEF);
    dt_req_i = 0; wb_ack_i = 1; wb_dat_i = 32'h0;
    cycle();
    check_eq("store_ack", 32'(dt_ack_o), 32'd1);
    wb_ack_i = 0;
    cycle();

    // Flushed fetch completes on the bus but reports nothing
    if_req_i = 1; if_adr_i = 32'h3000;
    cycle();
    if_req_i = 0; flush_i = 1;
    cycle();
    flush_i = 0; wb_ack_i = 1; wb_dat_i = 32'h55555555;
    cycle();
    check_eq("flush_no_ack", 32'(if_ack_o), 32'd0);
    check_eq("flush_dat_hold", if_dat_o, 32'h0123ABCD);
    check_eq("flush_cyc_done", 32'(wb_cyc_o), 32'd0);
    wb_ack_i = 0;
    cycle();
    if_req_i = 1; if_adr_i = 32'h3004;
    cycle();
    if_req_i = 0; wb_ack_i = 1; wb_dat_i = 32'h77;
    cycle();
    check_eq("post_flush_ack", 32'(if_ack_o), 32'd1);
    check_eq("post_flush_dat", if_dat_o, 32'h77);
    wb_ack_i = 0;
    cycle();

    // Random traffic, including stray acks and flushes while idle
    for (int i = 0; i < 3000; i++) begin
      if_req_i = ($urandom_range(0, 3) != 0);
      if_adr_i = $urandom;
      flush_i  = ($urandom_range(0, 15) == 0);
      dt_req_i = ($urandom_range(0, 2) != 0);
      dt_we_i  = 1'($urandom_range(0, 1));
      dt_adr_i = $urandom;
      dt_dat_i = $urandom;
      dt_sel_i = 4'($urandom_range(0, 15));
      wb_ack_i = ($urandom_range(0, 2) == 0);
      wb_dat_i = $urandom;
      cycle();
    end
    drain();

    // Asynchronous reset in the middle of a data cycle
    dt_req_i = 1; dt_we_i = 0; dt_adr_i = 32'h4000; dt_sel_i = 4'hF;
    cycle();
    check_eq("pre_reset_cyc", 32'(wb_cyc_o), 32'd1);
    dt_req_i = 0; if_req_i = 1; if_adr_i = 32'h5000;
    #2 rst_i = 0;
    #1;
    model_reset();
    check_eq("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("rst_dt_ack", 32'(dt_ack_o), 32'd0);
    check_eq("rst_adr", wb_adr_o, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    compare_all();
    rst_i = 1;
    cycle();
    check_eq("post_rst_fetch_adr", wb_adr_o, 32'h5000);
    check_eq("post_rst_fetch_cyc", 32'(wb_cyc_o), 32'd1);
    if_req_i = 0; wb_ack_i = 1; wb_dat_i = 32'hA5A5A5A5;
    cycle();
    check_eq("post_rst_fetch_ack", 32'(if_ack_o), 32'd1);
    wb_ack_i = 0;
    cycle();

`ifdef CPU_MEM_ARBITER_TIMEOUT_EN
    // Silent memory: abort on the 64th bus edge
    dt_req_i = 1; dt_adr_i = 32'h6000;
    cycle();
    dt_req_i = 0;
    repeat (TMO - 1) cycle();
    check_eq("tmo_not_yet", 32'(dt_err_o), 32'd0);
    cycle();
    check_eq("tmo_err", 32'(dt_err_o), 32'd1);
    check_eq("tmo_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("tmo_no_ack", 32'(dt_ack_o), 32'd0);
    cycle();
    // Ack on the timeout edge completes normally
    dt_req_i = 1;
    cycle();
    dt_req_i = 0;
    repeat (TMO - 1) cycle();
    wb_ack_i = 1; wb_dat_i = 32'hCAFE0001;
    cycle();
    check_eq("tmo_race_ack", 32'(dt_ack_o), 32'd1);
    check_eq("tmo_race_err", 32'(dt_err_o), 32'd0);
    wb_ack_i = 0;
    cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
